// File: rtl/performance_counter_access.sv
// performance_counter_access
//   Register-mapped access port for the performance counter block.
//   - Holds the per-counter event select registers and drives them to the counter block.
//   - Exposes each 64-bit count as two 32-bit words.
//   - Reading the low word captures the high word into a shadow register.
//     A later high-word read returns that shadow, so a LO-then-HI pair cannot tear.
//   - Every request gets a registered response exactly one cycle later.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   req_valid/write     request strobe and direction (1 = write)
//   req_addr[5:0]       word address
//   req_wdata[31:0]     write data
//   resp_valid/error    registered response strobe and error flag
//   resp_rdata[31:0]    registered read data (0 on writes and errors)
//   perf_event_count    live 64-bit counts from the counter block
//   perf_event_select   event select per counter
//
// Register map (word addresses)
//   0x00+i   SELECT[i]    read/write, low EVENT_IDX_WIDTH bits
//   0x10+2i  COUNT_LO[i]  read-only, captures the high word into the shadow
//   0x11+2i  COUNT_HI[i]  read-only, returns the shadow
module performance_counter_access #(
   parameter int NUM_EVENTS        = 8,
   parameter int EVENT_IDX_WIDTH   = $clog2(NUM_EVENTS),
   parameter int NUM_COUNTERS      = 2,
   parameter int COUNTER_IDX_WIDTH = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
   input  logic                                            clk,
   input  logic                                            reset_n,
   input  logic                                            req_valid,
   input  logic                                            req_write,
   input  logic [5:0]                                      req_addr,
   input  logic [31:0]                                     req_wdata,
   output logic                                            resp_valid,
   output logic                                            resp_error,
   output logic [31:0]                                     resp_rdata,
   input  logic [NUM_COUNTERS-1:0][63:0]                   perf_event_count,
   output logic [NUM_COUNTERS-1:0][EVENT_IDX_WIDTH-1:0]    perf_event_select
);

   logic                                          resp_valid_q, resp_valid_d;
   logic                                          resp_error_q, resp_error_d;
   logic [31:0]                                   resp_rdata_q, resp_rdata_d;
   logic [NUM_COUNTERS-1:0][EVENT_IDX_WIDTH-1:0]  sel_q, sel_d;
   logic [NUM_COUNTERS-1:0][31:0]                 shadow_q, shadow_d;

   logic                          hit_sel;
   logic                          hit_cnt;
   logic [COUNTER_IDX_WIDTH-1:0]  hit_idx;

   // Select bits above the field width are discarded by design.
   logic unused_wdata;
   assign unused_wdata = ^req_wdata[31:EVENT_IDX_WIDTH];

   // Address decode. Looping over the implemented counters keeps
   // out-of-range indices from ever reaching the array selects.
   always_comb begin
      hit_sel = 1'b0;
      hit_cnt = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < NUM_COUNTERS; i++) begin
         if (req_addr == 6'(i)) begin
            hit_sel = 1'b1;
            hit_idx = COUNTER_IDX_WIDTH'(i);
         end
         if (req_addr[5:1] == 5'(8 + i)) begin
            hit_cnt = 1'b1;
            hit_idx = COUNTER_IDX_WIDTH'(i);
         end
      end
   end

   always_comb begin
      resp_valid_d = req_valid;
      resp_error_d = 1'b0;
      resp_rdata_d = '0;
      sel_d        = sel_q;
      shadow_d     = shadow_q;
      if (req_valid) begin
         if (hit_sel) begin
            if (req_write) begin
               sel_d[hit_idx] = req_wdata[EVENT_IDX_WIDTH-1:0];
            end else begin
               resp_rdata_d = 32'(sel_q[hit_idx]);
            end
         end else if (hit_cnt) begin
            if (req_write) begin
               resp_error_d = 1'b1;
            end else if (!req_addr[0]) begin
               // LO and shadowed HI come from the same pre-edge sample.
               resp_rdata_d      = perf_event_count[hit_idx][31:0];
               shadow_d[hit_idx] = perf_event_count[hit_idx][63:32];
            end else begin
               resp_rdata_d = shadow_q[hit_idx];
            end
         end else begin
            resp_error_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_rdata_q <= '0;
         shadow_q     <= '0;
         for (int i = 0; i < NUM_COUNTERS; i++) begin
            sel_q[i] <= EVENT_IDX_WIDTH'(i % NUM_EVENTS);
         end
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_error_q <= resp_error_d;
         resp_rdata_q <= resp_rdata_d;
         shadow_q     <= shadow_d;
         sel_q        <= sel_d;
      end
   end

   assign resp_valid        = resp_valid_q;
   assign resp_error        = resp_error_q;
   assign resp_rdata        = resp_rdata_q;
   assign perf_event_select = sel_q;

endmodule

// File: tb/tb_performance_counter_access.sv
module tb_performance_counter_access;

   logic              clk;
   logic              reset_n;
   logic              req_valid;
   logic              req_write;
   logic [5:0]        req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_error;
   logic [31:0]       resp_rdata;
   logic [1:0][63:0]  perf_event_count;
   logic [1:0][2:0]   perf_event_select;

   logic [63:0] base0, base1, ticks;
   logic        inc_en;

   int total = 0;
   int bad   = 0;

   performance_counter_access dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .req_valid         (req_valid),
      .req_write         (req_write),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .resp_valid        (resp_valid),
      .resp_error        (resp_error),
      .resp_rdata        (resp_rdata),
      .perf_event_count  (perf_event_count),
      .perf_event_select (perf_event_select)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter 0 can free-run from base0; counter 1 is static.
   always @(posedge clk) ticks <= inc_en ? ticks + 64'd1 : 64'd0;
   assign perf_event_count = {base1, base0 + ticks};

   typedef struct {
      logic        wr;
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [5:0]  exp_sel;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // One request, then check its response one cycle later.
   task automatic xfer(input string name, input logic wr, input logic [5:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk);
      #1;
      check({name, ".valid"}, 32'(resp_valid), 32'd1);
      check({name, ".err"},   32'(resp_error), 32'(exp_err));
      check({name, ".rdata"}, resp_rdata,      exp_rd);
   endtask

   task automatic idle(input string name);
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'b0;
      @(posedge clk);
      #1;
      check({name, ".valid"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      //                wr    addr    wdata          rdata         err   sel{1,0}
      vecs[0]  = '{1'b0, 6'h00, 32'h0,         32'h0, 1'b0, 6'h08};
      vecs[1]  = '{1'b0, 6'h01, 32'h0,         32'h1, 1'b0, 6'h08};
      vecs[2]  = '{1'b1, 6'h01, 32'h5,         32'h0, 1'b0, 6'h28};
      vecs[3]  = '{1'b0, 6'h01, 32'h0,         32'h5, 1'b0, 6'h28};
      vecs[4]  = '{1'b1, 6'h01, 32'hFFFFFFFD,  32'h0, 1'b0, 6'h28};
      vecs[5]  = '{1'b0, 6'h01, 32'h0,         32'h5, 1'b0, 6'h28};
      vecs[6]  = '{1'b0, 6'h3F, 32'h0,         32'h0, 1'b1, 6'h28};
      vecs[7]  = '{1'b0, 6'h14, 32'h0,         32'h0, 1'b1, 6'h28};
      vecs[8]  = '{1'b1, 6'h02, 32'h7,         32'h0, 1'b1, 6'h28};
      vecs[9]  = '{1'b0, 6'h02, 32'h0,         32'h0, 1'b1, 6'h28};
      vecs[10] = '{1'b1, 6'h3F, 32'h1,         32'h0, 1'b1, 6'h28};
      vecs[11] = '{1'b1, 6'h00, 32'h9,         32'h0, 1'b0, 6'h29};
      vecs[12] = '{1'b0, 6'h00, 32'h0,         32'h1, 1'b0, 6'h29};
      vecs[13] = '{1'b1, 6'h00, 32'h6,         32'h0, 1'b0, 6'h2E};
      vecs[14] = '{1'b0, 6'h00, 32'h0,         32'h6, 1'b0, 6'h2E};
      vecs[15] = '{1'b0, 6'h15, 32'h0,         32'h0, 1'b1, 6'h2E};
      vecs[16] = '{1'b1, 6'h11, 32'h5,         32'h0, 1'b1, 6'h2E};

      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      inc_en    = 1'b0;
      base0     = 64'h0;
      base1     = 64'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.valid", 32'(resp_valid), 32'd0);
      check("rst.err",   32'(resp_error), 32'd0);
      check("rst.rdata", resp_rdata, 32'd0);
      check("rst.sel",   32'(perf_event_select), 32'h08);
      @(negedge clk);
      reset_n = 1'b1;
      idle("post_rst");

      // Table: select registers, decode errors, width truncation.
      for (int i = 0; i < 17; i++) begin
         xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rdata, vecs[i].exp_err);
         check($sformatf("vec%0d.sel", i), 32'(perf_event_select), 32'(vecs[i].exp_sel));
      end
      idle("post_table");

      // Low word wraps while the high word increments: HI must come from the shadow.
      base0  = 64'h0000_0000_FFFF_FFFF;
      inc_en = 1'b1;
      xfer("wrap_lo", 1'b0, 6'h10, 32'h0, 32'hFFFF_FFFF, 1'b0);
      idle("wrap_gap1");
      idle("wrap_gap2");
      xfer("wrap_hi", 1'b0, 6'h11, 32'h0, 32'h0000_0000, 1'b0);
      inc_en = 1'b0;
      idle("wrap_end");

      // Back-to-back reads of both counters.
      base0 = 64'h1111_2222_3333_4444;
      base1 = 64'h5555_6666_7777_8888;
      xfer("b2b_lo0", 1'b0, 6'h10, 32'h0, 32'h3333_4444, 1'b0);
      xfer("b2b_lo1", 1'b0, 6'h12, 32'h0, 32'h7777_8888, 1'b0);
      xfer("b2b_hi0", 1'b0, 6'h11, 32'h0, 32'h1111_2222, 1'b0);
      xfer("b2b_hi1", 1'b0, 6'h13, 32'h0, 32'h5555_6666, 1'b0);
      idle("b2b_end");

      // Writing a count register is rejected and leaves the shadow alone.
      base0 = 64'hAAAA_0001_0000_0010;
      xfer("ro_lo", 1'b0, 6'h10, 32'h0, 32'h0000_0010, 1'b0);
      base0 = 64'hBBBB_0000_0000_0000;
      xfer("ro_wr", 1'b1, 6'h10, 32'h123, 32'h0, 1'b1);
      xfer("ro_hi", 1'b0, 6'h11, 32'h0, 32'hAAAA_0001, 1'b0);

      // Reset while a response is on the outputs.
      base0 = 64'h0000_0042_0000_0001;
      xfer("pre_rst_lo", 1'b0, 6'h10, 32'h0, 32'h0000_0001, 1'b0);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 6'h11;
      @(posedge clk);
      #1;
      check("pend.valid", 32'(resp_valid), 32'd1);
      check("pend.rdata", resp_rdata, 32'h0000_0042);
      reset_n   = 1'b0;
      req_valid = 1'b0;
      #1;
      check("mid_rst.valid", 32'(resp_valid), 32'd0);
      check("mid_rst.rdata", resp_rdata, 32'd0);
      check("mid_rst.sel",   32'(perf_event_select), 32'h08);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("no_replay.valid", 32'(resp_valid), 32'd0);
      xfer("rst_hi", 1'b0, 6'h11, 32'h0, 32'h0, 1'b0);
      idle("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
